audio_env_pwm: RTL and testbench

Envelope shaper and PWM volume stage sitting directly downstream of the square-wave tone generator. Takes the generator's 1-bit tone plus a note gate, runs an attack/decay/sustain/release envelope producing an 8-bit level, and emits a 1-bit PWM output whose duty is the tone gated by that level. The result drives the board's audio pin through an external RC filter.

---
 rtl/audio_pkg.sv | 27 ++
 rtl/audio_env_step.sv | 61 ++++++
 rtl/audio_env_pwm.sv | 176 +++++++++++++++++
 tb/tb_audio_env_pwm.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the audio path: the envelope state
// encoding, default widths, the full-scale level, and constants shared with
// the square-wave tone generator.
// ---------------------------------------------------------------------------
package audio_pkg;

  // Envelope phases. IDLE is zero so that a reset state register is IDLE.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam int unsigned PRE_W_DEF = 8;      // default envelope prescaler width
  localparam int unsigned LVL_W_DEF = 8;      // default level / PWM width
  localparam int unsigned RATE_W    = 8;      // width of the rate inputs and rate counter
  localparam logic [7:0]  LVL_MAX   = 8'hFF;  // full-scale level at the default width

  // Constants shared with the tone generator.
  localparam int unsigned TONE_DIV_W   = 16;      // tone half-period divider width
  localparam logic [15:0] TONE_DIV_MIN = 16'd2;   // smallest legal half-period

endpackage

// File: rtl/audio_env_step.sv
// ---------------------------------------------------------------------------
// audio_env_step
// Envelope timebase. A free-running PRE_W-bit prescaler produces one tick
// per 2^PRE_W clocks; an 8-bit rate counter counts ticks and fires a
// one-clock step strobe on the (rate+1)-th tick, then starts over.
//
// Ports:
//   i_Clk    system clock (posedge)
//   i_Rst_L  asynchronous active-low reset
//   i_Rate   ticks per step minus 1 for the current envelope phase (live)
//   i_Clear  restart the rate count (envelope phase change)
//   o_Step   one-clock step strobe
// ---------------------------------------------------------------------------
module audio_env_step
  import audio_pkg::*;
#(
  parameter int unsigned PRE_W = PRE_W_DEF
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [RATE_W-1:0] i_Rate,
  input  logic              i_Clear,
  output logic              o_Step
);

  logic [PRE_W-1:0]  r_pre;
  logic [RATE_W-1:0] r_cnt;
  logic              w_tick;

  // Tick is high in the cycle whose closing edge wraps the prescaler to 0.
  assign w_tick = (r_pre == {PRE_W{1'b1}});

  // '>=' rather than '==' so a rate lowered below the running count still
  // fires at the next tick instead of waiting for the counter to wrap.
  assign o_Step = w_tick & (r_cnt >= i_Rate);

  // Free-running prescaler.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_pre <= {PRE_W{1'b0}};
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Tick counter: cleared on phase change (which takes priority) and on a step.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_cnt <= {RATE_W{1'b0}};
    end else if (i_Clear) begin
      r_cnt <= {RATE_W{1'b0}};
    end else if (o_Step) begin
      r_cnt <= {RATE_W{1'b0}};
    end else if (w_tick) begin
      r_cnt <= r_cnt + RATE_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/audio_env_pwm.sv
// ---------------------------------------------------------------------------
// audio_env_pwm
// ADSR envelope shaper plus PWM volume stage behind the tone generator.
// The envelope level gates the synchronised tone through a PWM compare; the
// output feeds the audio pin's external RC filter.
//
// Ports:
//   i_Clk           system clock (posedge)
//   i_Rst_L         asynchronous active-low reset
//   i_Tone          square wave from the tone generator (changes on negedge)
//   i_Gate          note on (1) / note off (0)
//   i_Attack_Rate   ticks per +1 step in ATTACK, minus 1
//   i_Decay_Rate    ticks per -1 step in DECAY, minus 1
//   i_Release_Rate  ticks per -1 step in RELEASE, minus 1
//   i_Sustain_Lvl   sustain level
//   o_Out           registered PWM audio output
//   o_Level         registered copy of the envelope level
//   o_Busy          registered "envelope not idle"
// ---------------------------------------------------------------------------
module audio_env_pwm
  import audio_pkg::*;
#(
  parameter int unsigned PRE_W = PRE_W_DEF,
  parameter int unsigned LVL_W = LVL_W_DEF
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Tone,
  input  logic              i_Gate,
  input  logic [RATE_W-1:0] i_Attack_Rate,
  input  logic [RATE_W-1:0] i_Decay_Rate,
  input  logic [RATE_W-1:0] i_Release_Rate,
  input  logic [LVL_W-1:0]  i_Sustain_Lvl,
  output logic              o_Out,
  output logic [LVL_W-1:0]  o_Level,
  output logic              o_Busy
);

  localparam logic [LVL_W-1:0] L_MAX  = {LVL_W{1'b1}};
  localparam logic [LVL_W-1:0] L_ZERO = {LVL_W{1'b0}};

  env_state_t        r_state;
  env_state_t        w_state_nxt;
  logic [LVL_W-1:0]  r_level;
  logic [LVL_W-1:0]  w_level_nxt;
  logic [LVL_W-1:0]  r_pwm_cnt;
  logic              r_tone_q;
  logic [RATE_W-1:0] w_rate;
  logic              w_step;
  logic              w_clear;

  // Pick the step rate of the active phase; IDLE and SUSTAIN never step.
  always_comb begin
    w_rate = {RATE_W{1'b0}};
    case (r_state)
      ATTACK:  w_rate = i_Attack_Rate;
      DECAY:   w_rate = i_Decay_Rate;
      RELEASE: w_rate = i_Release_Rate;
      default: w_rate = {RATE_W{1'b0}};
    endcase
  end

  // Any phase change restarts the rate count so the first step of a phase
  // lands on the (rate+1)-th tick after entering it.
  assign w_clear = (w_state_nxt != r_state);

  audio_env_step #(
    .PRE_W (PRE_W)
  ) u_step (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Rate  (w_rate),
    .i_Clear (w_clear),
    .o_Step  (w_step)
  );

  // Envelope next-state and next-level. Transitions are evaluated before the
  // step so that a transition in the same cycle suppresses the step.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    case (r_state)
      IDLE: begin
        w_level_nxt = L_ZERO;
        if (i_Gate) begin
          w_state_nxt = ATTACK;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ATTACK: begin
        if (!i_Gate) begin
          w_state_nxt = RELEASE;
        end else if (r_level == L_MAX) begin
          w_state_nxt = DECAY;
        end else if (w_step) begin
          w_level_nxt = r_level + LVL_W'(1);
        end else begin
          w_level_nxt = r_level;
        end
      end
      DECAY: begin
        // Also covers sustain at full scale: leaves DECAY on its first cycle.
        if (!i_Gate) begin
          w_state_nxt = RELEASE;
        end else if (r_level <= i_Sustain_Lvl) begin
          w_state_nxt = SUSTAIN;
        end else if (w_step) begin
          w_level_nxt = r_level - LVL_W'(1);
        end else begin
          w_level_nxt = r_level;
        end
      end
      SUSTAIN: begin
        // Level is held even if the sustain input is later lowered.
        if (!i_Gate) begin
          w_state_nxt = RELEASE;
        end else begin
          w_state_nxt = SUSTAIN;
        end
      end
      RELEASE: begin
        // Retrigger resumes ATTACK from the current level.
        if (i_Gate) begin
          w_state_nxt = ATTACK;
        end else if (r_level == L_ZERO) begin
          w_state_nxt = IDLE;
        end else if (w_step) begin
          w_level_nxt = r_level - LVL_W'(1);
        end else begin
          w_level_nxt = r_level;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_level_nxt = L_ZERO;
      end
    endcase
  end

  // Envelope state and level registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= IDLE;
      r_level <= L_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Tone resync (the generator changes it on the falling edge) and free-running PWM counter.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_tone_q  <= 1'b0;
      r_pwm_cnt <= L_ZERO;
    end else begin
      r_tone_q  <= i_Tone;
      r_pwm_cnt <= r_pwm_cnt + LVL_W'(1);
    end
  end

  // Registered outputs; level and busy trail the envelope registers by one clock.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Out   <= 1'b0;
      o_Level <= L_ZERO;
      o_Busy  <= 1'b0;
    end else begin
      o_Out   <= r_tone_q & (r_pwm_cnt < r_level);
      o_Level <= r_level;
      o_Busy  <= (r_state != IDLE);
    end
  end

endmodule

// File: tb/tb_audio_env_pwm.sv
// ---------------------------------------------------------------------------
// tb_audio_env_pwm
// Directed bench for audio_env_pwm at PRE_W=2 (one envelope tick per 4
// clocks). Multi-cycle envelope sequences are hand written; PWM duty at
// several sustain levels comes from a vector table.
// ---------------------------------------------------------------------------
module tb_audio_env_pwm;

  logic       clk;
  logic       rst_n;
  logic       tone;
  logic       gate;
  logic [7:0] atk_rate;
  logic [7:0] dec_rate;
  logic [7:0] rel_rate;
  logic [7:0] sus_lvl;
  logic       out_s;
  logic [7:0] level_s;
  logic       busy_s;

  int n_vec;
  int n_err;

  audio_env_pwm #(
    .PRE_W (2),
    .LVL_W (8)
  ) dut (
    .i_Clk          (clk),
    .i_Rst_L        (rst_n),
    .i_Tone         (tone),
    .i_Gate         (gate),
    .i_Attack_Rate  (atk_rate),
    .i_Decay_Rate   (dec_rate),
    .i_Release_Rate (rel_rate),
    .i_Sustain_Lvl  (sus_lvl),
    .o_Out          (out_s),
    .o_Level        (level_s),
    .o_Busy         (busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sus;
    logic       tone;
    int         exp_lvl;
    int         exp_duty;
  } vec_t;

  vec_t vt[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic wait_level(input int tgt, input int budget, input string name, output int cyc);
    cyc = 0;
    while ((int'(level_s) != tgt) && (cyc < budget)) begin
      tick();
      cyc++;
    end
    check(name, int'(level_s), tgt);
  endtask

  task automatic wait_change(input int budget, input string name, output int cyc);
    logic [7:0] prev;
    prev = level_s;
    cyc  = 0;
    while ((level_s == prev) && (cyc < budget)) begin
      tick();
      cyc++;
    end
    check(name, int'(level_s != prev), 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int cyc;
    cyc = 0;
    while (busy_s && (cyc < budget)) begin
      tick();
      cyc++;
    end
    check(name, int'(busy_s), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int hi;
    int mn;
    int changed;
    int lv;

    n_vec = 0;
    n_err = 0;

    // {sustain, tone, settled level, high clocks per 256}
    vt[0] = '{8'd255, 1'b1, 255, 255};
    vt[1] = '{8'd200, 1'b1, 200, 200};
    vt[2] = '{8'd128, 1'b1, 128, 128};
    vt[3] = '{8'd64,  1'b1, 64,  64};
    vt[4] = '{8'd64,  1'b0, 64,  0};
    vt[5] = '{8'd1,   1'b1, 1,   1};

    rst_n    = 1'b0;
    tone     = 1'b1;
    gate     = 1'b0;
    atk_rate = 8'd0;
    dec_rate = 8'd0;
    rel_rate = 8'd0;
    sus_lvl  = 8'd128;

    // Reset values.
    repeat (3) tick();
    check("rst_out", int'(out_s), 0);
    check("rst_level", int'(level_s), 0);
    check("rst_busy", int'(busy_s), 0);

    // Idle with tone high: level 0 keeps the output low.
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      hi += int'(out_s);
    end
    check("idle_out_zero", hi, 0);
    check("idle_busy", int'(busy_s), 0);

    // Attack at rate 0: 255 steps of 4 clocks, then decay to 128.
    gate = 1'b1;
    wait_level(255, 1200, "attack_reach_max", cyc);
    check("attack_time_window", int'((cyc >= 1016) && (cyc <= 1028)), 1);
    check("attack_busy", int'(busy_s), 1);
    wait_level(128, 700, "decay_reach_sus", cyc);
    check("decay_time_window", int'((cyc >= 500) && (cyc <= 516)), 1);
    changed = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (level_s != 8'd128) changed = 1;
    end
    check("sustain_hold", changed, 0);

    // Reset mid-note in SUSTAIN takes effect with no clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_level", int'(level_s), 0);
    check("midrst_busy", int'(busy_s), 0);
    check("midrst_out", int'(out_s), 0);
    gate = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    check("postrst_busy", int'(busy_s), 0);

    // Back to SUSTAIN at 128, then release at rate 1 (8 clocks per step).
    gate = 1'b1;
    wait_level(255, 1200, "renote_max", cyc);
    wait_level(128, 700, "renote_sus", cyc);
    rel_rate = 8'd1;
    gate     = 1'b0;
    wait_change(20, "release_first_step", cyc);
    wait_change(20, "release_step_a", cyc);
    check("release_period_a", cyc, 8);
    wait_change(20, "release_step_b", cyc);
    check("release_period_b", cyc, 8);

    // Retrigger at 60: attack resumes from the current level.
    wait_level(60, 700, "release_to_60", cyc);
    gate = 1'b1;
    mn = 255;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (int'(level_s) < mn) mn = int'(level_s);
    end
    check("retrig_no_drop", int'(mn >= 60), 1);
    repeat (200) tick();
    check("retrig_climbs", int'((level_s > 8'd60) && (level_s <= 8'd125)), 1);

    // Release all the way to 0; busy falls one clock after the level.
    gate = 1'b0;
    wait_level(0, 1500, "release_to_zero", cyc);
    check("zero_busy_still", int'(busy_s), 1);
    tick();
    check("zero_busy_fall", int'(busy_s), 0);

    // Gate drop on the clock of an attack step: step suppressed, RELEASE.
    gate = 1'b1;
    wait_level(100, 600, "attack_to_100", cyc);
    wait_change(10, "attack_step_seen", cyc);
    lv = int'(level_s);
    tick();
    tick();
    gate = 1'b0;
    tick();
    tick();
    check("drop_step_suppressed", int'(level_s), lv);
    check("drop_busy", int'(busy_s), 1);
    repeat (12) tick();
    check("drop_then_release", int'(level_s), lv - 1);
    wait_idle(1500, "drop_idle");

    // Sustain at full scale: ATTACK -> DECAY -> SUSTAIN with no level loss.
    rel_rate = 8'd0;
    sus_lvl  = 8'd255;
    gate     = 1'b1;
    wait_level(255, 1200, "sus255_max", cyc);
    changed = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (level_s != 8'd255) changed = 1;
    end
    check("sus255_hold", changed, 0);
    gate = 1'b0;
    wait_idle(1300, "sus255_idle");

    // PWM duty table.
    for (int v = 0; v < 6; v++) begin
      sus_lvl = vt[v].sus;
      tone    = 1'b0;
      gate    = 1'b1;
      wait_level(255, 1200, "tbl_max", cyc);
      wait_level(vt[v].exp_lvl, 1100, "tbl_settle", cyc);
      repeat (16) tick();
      check("tbl_level", int'(level_s), vt[v].exp_lvl);
      tone = vt[v].tone;
      repeat (4) tick();
      hi = 0;
      for (int i = 0; i < 256; i++) begin
        tick();
        hi += int'(out_s);
      end
      check("tbl_duty", hi, vt[v].exp_duty);
      tone = 1'b0;
      gate = 1'b0;
      wait_idle(1300, "tbl_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
